sort_readout: RTL and testbench

Streams the contents of the sorter's data memory out over a valid/ready interface once the sort control unit reports completion. Sits beside the sort control unit and datapath: it watches the control unit's `done` flag, owns the memory read port only while streaming, and presents one sorted word per cycle to the downstream consumer (display or serial TX). A 2-entry output buffer absorbs the 1-cycle synchronous memory read latency, so throughput is one word per cycle while `out_ready` stays high.

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_skid_fifo.sv | 98 +++++++++
 rtl/sort_readout.sv | 161 ++++++++++++++++
 tb/tb_sort_readout.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sorter: default word width and memory depth used
// by the datapath, the control unit and the readout block, plus the state
// encoding of the readout FSM.
// -----------------------------------------------------------------------------
package sort_pkg;

    localparam int SORT_DATA_W = 8;
    localparam int SORT_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2,
        WAIT_CLR = 2'd3
    } readout_state_t;

endpackage : sort_pkg

// File: rtl/sort_skid_fifo.sv
// -----------------------------------------------------------------------------
// sort_skid_fifo
// Two-entry register FIFO that absorbs the one-cycle read latency of the sort
// memory. The head entry is a plain register, so head_data_o / head_valid_o
// are registered outputs.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush_i       drop all entries (dominates push and pop)
//   push_i        write push_data_i into the tail
//   push_data_i   entry to write
//   pop_i         consume the head entry (ignored when empty)
//   count_o       number of valid entries (0..2)
//   head_data_o   head entry
//   head_valid_o  head entry is valid
// -----------------------------------------------------------------------------
module sort_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop_eff;

    assign pop_eff = pop_i && (count_q != 2'd0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop_eff})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_data_i;
                    end else begin
                        tail_d = push_data_i;
                    end
                    // Saturate; a push into a full buffer is flagged below.
                    count_d = (count_q == 2'd2) ? 2'd2 : count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous write and pop: occupancy is unchanged.
                    if (count_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well; the head drives the block's outputs, which must read 0 out of reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_data_o  = head_q;
    assign head_valid_o = (count_q != 2'd0);

    // The readout only issues a read when there is room for it, so a write
    // into a full buffer means the issue logic is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_eff && !flush_i && (count_q == 2'd2)));

endmodule : sort_skid_fifo

// File: rtl/sort_readout.sv
// -----------------------------------------------------------------------------
// sort_readout
// Streams the sort memory out over a valid/ready interface once the sort
// control unit reports completion, one word per cycle while out_ready is high.
// Exactly one pass is produced per assertion of done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   done       sort-complete level from the control unit
//   rd_en      memory read enable
//   rd_addr    memory read address
//   rd_data    memory read data, valid the cycle after rd_en
//   out_data   streamed word (registered)
//   out_valid  out_data is valid
//   out_ready  consumer accepts the word this cycle
//   out_last   final word of a pass
//   busy       readout pass in progress (STREAM or DRAIN)
// -----------------------------------------------------------------------------
module sort_readout
    import sort_pkg::*;
#(
    parameter int DATA_W  = SORT_DATA_W,
    parameter int DEPTH   = SORT_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    // The pass length is tracked by its own count so non-power-of-2 depths
    // do not depend on address wrap.
    localparam int                ISS_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] START_ADDR = DESCEND ? ADDR_W'(DEPTH - 1) : '0;
    localparam logic [ISS_W-1:0]  LAST_ISSUE = ISS_W'(DEPTH - 1);

    readout_state_t    state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ISS_W-1:0]  issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic              issue;
    logic              flush;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   head_data;
    logic              head_valid;
    logic [2:0]        held;
    logic              room;

    assign pop = head_valid && out_ready;

    // Words already committed to the buffer: stored entries plus the read
    // whose data arrives this cycle. A pop this cycle frees one slot.
    assign held = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign room = held < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        issue    = 1'b0;
        flush    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (done) begin
                    state_d  = STREAM;
                    cnt_d    = START_ADDR;
                    issued_d = '0;
                end
            end
            STREAM: begin
                if (!done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    issued_d = '0;
                    flush    = 1'b1;
                end else if (room) begin
                    issue    = 1'b1;
                    cnt_d    = DESCEND ? cnt_q - ADDR_W'(1) : cnt_q + ADDR_W'(1);
                    issued_d = issued_q + ISS_W'(1);
                    if (issued_q == LAST_ISSUE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!done) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    issued_d = '0;
                    flush    = 1'b1;
                end else if (!inflight_q &&
                             ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    // The buffer is empty after this edge and nothing is coming.
                    state_d = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An aborted pass never issues, so the pending read is discarded here.
        inflight_d      = issue;
        inflight_last_d = issue && (issued_q == LAST_ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    sort_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst),
        .flush_i      (flush),
        .push_i       (inflight_q),
        .push_data_i  ({inflight_last_q, rd_data}),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_data_o  (head_data),
        .head_valid_o (head_valid)
    );

    assign rd_en     = issue;
    assign rd_addr   = issue ? cnt_q : '0;
    assign out_data  = head_data[DATA_W-1:0];
    assign out_valid = head_valid;
    assign out_last  = head_valid && head_data[DATA_W];
    assign busy      = (state_q == STREAM) || (state_q == DRAIN);

endmodule : sort_readout

// File: tb/tb_sort_readout.sv
// -----------------------------------------------------------------------------
// tb_sort_readout
// Three readout instances: ascending DEPTH=8, descending DEPTH=8 and ascending
// DEPTH=5, each with its own memory model. Expected words come from reading
// the memory arrays in pass order; occupancy is modelled as reads issued minus
// words accepted.
// -----------------------------------------------------------------------------
module tb_sort_readout;

    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       done      [3];
    logic       ready     [3];
    logic       rd_en     [3];
    logic [2:0] rd_addr   [3];
    logic [7:0] rd_data   [3];
    logic [7:0] out_data  [3];
    logic       out_valid [3];
    logic       out_last  [3];
    logic       busy      [3];
    logic [7:0] mem       [3][8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sort_readout #(.DATA_W(8), .DEPTH(8), .DESCEND(1'b0)) dut_asc (
        .clk(clk), .rst(rst), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_ready(ready[0]), .out_last(out_last[0]), .busy(busy[0]));

    sort_readout #(.DATA_W(8), .DEPTH(8), .DESCEND(1'b1)) dut_desc (
        .clk(clk), .rst(rst), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_ready(ready[1]), .out_last(out_last[1]), .busy(busy[1]));

    sort_readout #(.DATA_W(8), .DEPTH(5), .DESCEND(1'b0)) dut_d5 (
        .clk(clk), .rst(rst), .done(done[2]), .rd_en(rd_en[2]), .rd_addr(rd_addr[2]),
        .rd_data(rd_data[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .out_ready(ready[2]), .out_last(out_last[2]), .busy(busy[2]));

    // Synchronous-read memories, one per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en[k]) rd_data[k] <= mem[k][rd_addr[k]];
        end
    end

    // Per-pass observations.
    logic       ob_busy  [MAXC];
    logic       ob_valid [MAXC];
    logic       ob_rden  [MAXC];
    logic [2:0] ob_addr  [MAXC];
    logic [7:0] acc_data [$];
    logic       acc_last [$];
    int         acc_cyc  [$];
    int         addr_q   [$];
    int         stab_err, over_err, abort_cyc, reads;

    // Reference model: word i of a pass for instance k.
    function automatic logic [7:0] model_word(input int k, input int i);
        int depth = (k == 2) ? 5 : 8;
        int idx   = (k == 1) ? depth - 1 - i : i;
        return mem[k][idx];
    endfunction

    function automatic int model_depth(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int k);
        for (int i = 0; i < 8; i++) mem[k][i] = 8'($urandom);
    endtask

    task automatic idle_done(input int k);
        done[k]  = 1'b0;
        ready[k] = 1'b0;
        repeat (3) tick();
    endtask

    // Raises done at cycle 0 and records ncyc cycles. mode: 0 ready high,
    // 1 pattern 1,0,0,1,0,1, 2 random. abort_after >= 0 drops done (and
    // ready) the cycle after that many words were accepted.
    task automatic collect(input int k, input int mode, input int ncyc, input int abort_after);
        int         outstanding = 0;
        int         ph = 0;
        logic       pv = 1'b0;
        logic       pr = 1'b1;
        logic [7:0] pd = '0;
        logic       pop;
        acc_data.delete(); acc_last.delete(); acc_cyc.delete(); addr_q.delete();
        stab_err = 0; over_err = 0; abort_cyc = -1; reads = 0;
        done[k] = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            if (abort_cyc >= 0 && c >= abort_cyc) begin
                done[k]  = 1'b0;
                ready[k] = 1'b0;
            end else begin
                case (mode)
                    0:       ready[k] = 1'b1;
                    1:       ready[k] = (ph == 0) || (ph == 3) || (ph == 5);
                    default: ready[k] = 1'($urandom_range(0, 1));
                endcase
            end
            ph = (ph == 5) ? 0 : ph + 1;
            #1;
            ob_busy[c]  = busy[k];
            ob_valid[c] = out_valid[k];
            ob_rden[c]  = rd_en[k];
            ob_addr[c]  = rd_addr[k];
            pop = out_valid[k] && ready[k];
            if (pv && !pr && (abort_cyc < 0 || c <= abort_cyc) &&
                (!out_valid[k] || out_data[k] !== pd)) stab_err++;
            if (rd_en[k]) begin
                if (outstanding - int'(pop) >= 2) over_err++;
                reads++;
                addr_q.push_back(int'(rd_addr[k]));
            end
            if (pop) begin
                acc_data.push_back(out_data[k]);
                acc_last.push_back(out_last[k]);
                acc_cyc.push_back(c);
            end
            outstanding = outstanding + int'(rd_en[k]) - int'(pop);
            pv = out_valid[k]; pd = out_data[k]; pr = ready[k];
            if (abort_after >= 0 && abort_cyc < 0 && acc_data.size() == abort_after)
                abort_cyc = c + 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin done[k] = 1'b0; ready[k] = 1'b0; end
        for (int i = 0; i < 8; i++) begin mem[0][i] = '0; mem[1][i] = '0; mem[2][i] = '0; end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({rd_en[k], rd_addr[k], out_data[k], out_valid[k], out_last[k], busy[k]} !== 15'd0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got rd_en=%0b addr=%0d data=%0h valid=%0b last=%0b busy=%0b, want all 0",
                         k, rd_en[k], rd_addr[k], out_data[k], out_valid[k], out_last[k], busy[k]);
            end
        end
        #2 rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] init [8] = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
        for (int i = 0; i < 8; i++) mem[0][i] = init[i];
        collect(0, 0, 24, -1);
        total++;
        if (acc_data.size() != 8) begin
            bad++; $display("FAIL basic_count: got %0d words, want 8", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 8; i++) begin
            total++;
            if (acc_data[i] !== model_word(0, i) || acc_cyc[i] != 3 + i || acc_last[i] !== (i == 7)) begin
                bad++;
                $display("FAIL basic_word[%0d]: got %0d cyc=%0d last=%0b, want %0d cyc=%0d last=%0b",
                         i, acc_data[i], acc_cyc[i], acc_last[i], model_word(0, i), 3 + i, (i == 7));
            end
        end
        for (int c = 0; c < 24; c++) begin
            total++;
            if (ob_busy[c] !== (c >= 1 && c <= 10) || ob_rden[c] !== (c >= 1 && c <= 8) ||
                (c >= 1 && c <= 8 && ob_addr[c] !== 3'(c - 1))) begin
                bad++;
                $display("FAIL basic_timing[cyc %0d]: got busy=%0b rd_en=%0b addr=%0d, want busy=%0b rd_en=%0b addr=%0d",
                         c, ob_busy[c], ob_rden[c], ob_addr[c], (c >= 1 && c <= 10), (c >= 1 && c <= 8), c - 1);
            end
        end
        idle_done(0);
    endtask

    task automatic test_descend();
        logic [7:0] init [8] = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
        for (int i = 0; i < 8; i++) mem[1][i] = init[i];
        collect(1, 0, 16, -1);
        total++;
        if (acc_data.size() != 8) begin
            bad++; $display("FAIL desc_count: got %0d words, want 8", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 8; i++) begin
            total++;
            if (acc_data[i] !== init[7 - i] || acc_cyc[i] != 3 + i || acc_last[i] !== (i == 7)) begin
                bad++;
                $display("FAIL desc_word[%0d]: got %0d cyc=%0d last=%0b, want %0d cyc=%0d last=%0b",
                         i, acc_data[i], acc_cyc[i], acc_last[i], init[7 - i], 3 + i, (i == 7));
            end
        end
        for (int c = 1; c <= 8; c++) begin
            total++;
            if (ob_rden[c] !== 1'b1 || ob_addr[c] !== 3'(8 - c)) begin
                bad++;
                $display("FAIL desc_addr[cyc %0d]: got rd_en=%0b addr=%0d, want rd_en=1 addr=%0d",
                         c, ob_rden[c], ob_addr[c], 8 - c);
            end
        end
        idle_done(1);
    endtask

    // Shared by the stalled-consumer scenarios: order, last tag, stability,
    // and the two-word limit.
    task automatic test_stall(input int k, input int mode, input int ncyc, input string name);
        int depth = model_depth(k);
        fill_random(k);
        collect(k, mode, ncyc, -1);
        total++;
        if (acc_data.size() != depth || reads != depth) begin
            bad++; $display("FAIL %s_count: got %0d words %0d reads, want %0d", name, acc_data.size(), reads, depth);
        end
        for (int i = 0; i < acc_data.size() && i < depth; i++) begin
            total++;
            if (acc_data[i] !== model_word(k, i) || acc_last[i] !== (i == depth - 1)) begin
                bad++;
                $display("FAIL %s_word[%0d]: got %0h last=%0b, want %0h last=%0b",
                         name, i, acc_data[i], acc_last[i], model_word(k, i), (i == depth - 1));
            end
        end
        total++;
        if (stab_err != 0 || over_err != 0) begin
            bad++; $display("FAIL %s_hold: got %0d unstable cycles %0d over-issues, want 0 and 0", name, stab_err, over_err);
        end
        idle_done(k);
    endtask

    task automatic test_abort();
        fill_random(0);
        collect(0, 0, 16, 3);
        total++;
        if (abort_cyc < 0 || acc_data.size() != 3) begin
            bad++; $display("FAIL abort_count: got %0d words (abort cyc %0d), want 3", acc_data.size(), abort_cyc);
        end
        for (int i = 0; i < acc_data.size() && i < 3; i++) begin
            total++;
            if (acc_data[i] !== model_word(0, i) || acc_last[i] !== 1'b0) begin
                bad++;
                $display("FAIL abort_word[%0d]: got %0h last=%0b, want %0h last=0", i, acc_data[i], acc_last[i], model_word(0, i));
            end
        end
        for (int c = (abort_cyc < 0 ? 15 : abort_cyc + 1); c < 16; c++) begin
            total++;
            if (ob_valid[c] !== 1'b0 || ob_rden[c] !== 1'b0 || ob_busy[c] !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle[cyc %0d]: got valid=%0b rd_en=%0b busy=%0b, want 0 0 0", c, ob_valid[c], ob_rden[c], ob_busy[c]);
            end
        end
        // A fresh done gives a complete pass from word 0.
        collect(0, 0, 16, -1);
        total++;
        if (acc_data.size() != 8) begin
            bad++; $display("FAIL abort_repass_count: got %0d words, want 8", acc_data.size());
        end
        for (int i = 0; i < acc_data.size() && i < 8; i++) begin
            total++;
            if (acc_data[i] !== model_word(0, i) || acc_cyc[i] != 3 + i || acc_last[i] !== (i == 7)) begin
                bad++;
                $display("FAIL abort_repass_word[%0d]: got %0h cyc=%0d last=%0b, want %0h cyc=%0d last=%0b",
                         i, acc_data[i], acc_cyc[i], acc_last[i], model_word(0, i), 3 + i, (i == 7));
            end
        end
        idle_done(0);
    endtask

    task automatic test_reset_mid();
        fill_random(0);
        collect(0, 0, 10, -1);
        total++;
        if (ob_busy[9] !== 1'b1 || ob_rden[9] !== 1'b0) begin
            bad++; $display("FAIL rstmid_drain: got busy=%0b rd_en=%0b at cyc 9, want busy=1 rd_en=0", ob_busy[9], ob_rden[9]);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({rd_en[0], rd_addr[0], out_data[0], out_valid[0], out_last[0], busy[0]} !== 15'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: got rd_en=%0b addr=%0d data=%0h valid=%0b last=%0b busy=%0b, want all 0",
                     rd_en[0], rd_addr[0], out_data[0], out_valid[0], out_last[0], busy[0]);
        end
        rst = 1'b1;
        #1;
        collect(0, 0, 16, -1);
        total++;
        if (acc_data.size() != 8 || ob_rden[1] !== 1'b1 || ob_addr[1] !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_repass: got %0d words rd_en@1=%0b addr@1=%0d, want 8 words rd_en@1=1 addr@1=0",
                     acc_data.size(), ob_rden[1], ob_addr[1]);
        end
        for (int i = 0; i < acc_data.size() && i < 8; i++) begin
            total++;
            if (acc_data[i] !== model_word(0, i) || acc_cyc[i] != 3 + i) begin
                bad++;
                $display("FAIL rstmid_word[%0d]: got %0h cyc=%0d, want %0h cyc=%0d", i, acc_data[i], acc_cyc[i], model_word(0, i), 3 + i);
            end
        end
        idle_done(0);
    endtask

    task automatic test_depth5();
        fill_random(2);
        collect(2, 0, 16, -1);
        total++;
        if (acc_data.size() != 5 || reads != 5) begin
            bad++; $display("FAIL d5_count: got %0d words %0d reads, want 5 and 5", acc_data.size(), reads);
        end
        for (int i = 0; i < addr_q.size() && i < 5; i++) begin
            total++;
            if (addr_q[i] != i) begin
                bad++; $display("FAIL d5_addr[%0d]: got %0d, want %0d", i, addr_q[i], i);
            end
        end
        for (int i = 0; i < acc_data.size() && i < 5; i++) begin
            total++;
            if (acc_data[i] !== model_word(2, i) || acc_cyc[i] != 3 + i || acc_last[i] !== (i == 4)) begin
                bad++;
                $display("FAIL d5_word[%0d]: got %0h cyc=%0d last=%0b, want %0h cyc=%0d last=%0b",
                         i, acc_data[i], acc_cyc[i], acc_last[i], model_word(2, i), 3 + i, (i == 4));
            end
        end
        total++;
        if (ob_busy[7] !== 1'b1 || ob_busy[8] !== 1'b0) begin
            bad++; $display("FAIL d5_busy: got busy@7=%0b busy@8=%0b, want 1 and 0", ob_busy[7], ob_busy[8]);
        end
        idle_done(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_descend();
        test_stall(0, 1, 48, "backpressure");
        test_stall(1, 2, 96, "random_ready_desc");
        test_stall(2, 2, 80, "random_ready_d5");
        test_abort();
        test_reset_mid();
        test_depth5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_sort_readout
